// File: rtl/reaction_timer.sv
// reaction_timer: arms on a start press, lights "go" after a pseudo-random delay,
// then measures the hit reaction in BCD milliseconds (early-press and 9999 saturation handling).
module reaction_timer #(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int MIN_DELAY_MS = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_hit,
    output logic        led_go,
    output logic        led_early,
    output logic        busy,
    output logic [15:0] result_bcd,
    output logic        result_valid,
    output logic        timeout
);
    localparam int MS_DIV = CLK_FREQ / 1000;
    localparam int PW     = $clog2(MS_DIV);

    typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, EARLY} state_t;

    state_t        state_q, state_d;
    logic          prev_start_q, prev_hit_q;
    logic [15:0]   lfsr_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [13:0]   delay_q, delay_d, dcnt_q, dcnt_d;
    logic [15:0]   res_q, res_d, res_inc;
    logic          tmo_q, tmo_d, valid_q, go_q, early_q, busy_q;
    logic          start_e, hit_e, tick, carry;

    assign start_e = btn_start & ~prev_start_q;
    assign hit_e   = btn_hit & ~prev_hit_q;
    assign tick    = pre_q == PW'(MS_DIV - 1);

    always_comb begin
        res_inc = res_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_inc[4*i +: 4] = carry ? (res_q[4*i +: 4] == 4'd9 ? 4'd0 : res_q[4*i +: 4] + 4'd1)
                                      : res_q[4*i +: 4];
            carry = carry & (res_q[4*i +: 4] == 4'd9);
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = tick ? '0 : pre_q + PW'(1);
        delay_d = delay_q;
        dcnt_d  = dcnt_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE, DONE, EARLY: begin
                if (start_e) begin
                    state_d = WAIT;
                    delay_d = 14'(MIN_DELAY_MS) + 14'(lfsr_q[10:0]);
                    dcnt_d  = '0;
                    pre_d   = '0;
                    tmo_d   = 1'b0;
                end
            end
            WAIT: begin
                if (hit_e) begin
                    state_d = EARLY;
                    res_d   = '0;
                end else if (tick) begin
                    dcnt_d = dcnt_q + 14'd1;
                    // >= so a zero-length delay still leaves WAIT after one ms
                    if (dcnt_d >= delay_q) begin
                        state_d = GO;
                        res_d   = '0;
                        pre_d   = '0;
                    end
                end
            end
            GO: begin
                if (hit_e) state_d = DONE;
                else if (tick) begin
                    if (res_q == 16'h9999) begin
                        state_d = DONE;
                        tmo_d   = 1'b1;
                    end else res_d = res_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prev_start_q <= 1'b1;
            prev_hit_q   <= 1'b1;
            lfsr_q       <= 16'hACE1;
            pre_q        <= '0;
            delay_q      <= '0;
            dcnt_q       <= '0;
            res_q        <= '0;
            tmo_q        <= 1'b0;
            valid_q      <= 1'b0;
            go_q         <= 1'b0;
            early_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_start_q <= btn_start;
            prev_hit_q   <= btn_hit;
            lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            pre_q        <= pre_d;
            delay_q      <= delay_d;
            dcnt_q       <= dcnt_d;
            res_q        <= res_d;
            tmo_q        <= tmo_d;
            valid_q      <= state_d == DONE && state_q != DONE;
            go_q         <= state_d == GO;
            early_q      <= state_d == EARLY;
            busy_q       <= state_d == WAIT || state_d == GO;
        end
    end

    assign led_go       = go_q;
    assign led_early    = early_q;
    assign busy         = busy_q;
    assign result_bcd   = res_q;
    assign result_valid = valid_q;
    assign timeout      = tmo_q;
endmodule
